// File: rtl/counter_sweep_ctrl_if.sv
// Signal bundle between the sweep sequencer, its host and the companion
// up/down counter. The controller sits on the slave side; whoever drives
// commands and returns the counter feedback uses the master side.
interface counter_sweep_ctrl_if #(
    parameter int N  = 4,
    parameter int SW = 4
);
    // host command side
    logic          start;
    logic          stop;
    logic [N-1:0]  lo;
    logic [N-1:0]  hi;
    logic [SW-1:0] sweeps;
    logic          busy;
    logic          done;
    logic          error;
    logic [SW-1:0] sweep_cnt;

    // counter side
    logic [N-1:0]  cnt_value;
    logic          cnt_threshold;
    logic          cnt_enable;
    logic          cnt_dec;
    logic          cnt_load;
    logic [N-1:0]  cnt_ref;

    modport master (
        output start, stop, lo, hi, sweeps, cnt_value, cnt_threshold,
        input  busy, done, error, sweep_cnt, cnt_enable, cnt_dec, cnt_load, cnt_ref
    );

    modport slave (
        input  start, stop, lo, hi, sweeps, cnt_value, cnt_threshold,
        output busy, done, error, sweep_cnt, cnt_enable, cnt_dec, cnt_load, cnt_ref
    );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer for the lab up/down counter: loads lo, ramps to hi and back
// to lo a programmed number of times, one step per prescaler tick.
module counter_sweep_ctrl #(
    parameter int N        = 4,
    parameter int TICK_DIV = 4,
    parameter int SW       = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    counter_sweep_ctrl_if.slave   bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_reg, state_next;
    logic [N-1:0]  lo_reg, hi_reg;
    logic [SW-1:0] sw_reg;
    logic [SW-1:0] sweep_cnt_reg, sweep_cnt_plus;
    logic          error_reg;
    logic [PW-1:0] presc_reg, presc_next;

    logic          tick;
    logic          capture;
    logic          sweep_inc;
    logic          step_en;
    logic          step_dec;
    logic          load_strobe;

    assign tick           = (presc_reg == TICK_LAST);
    assign sweep_cnt_plus = sweep_cnt_reg + 1'b1;

    // Next-state and counter strobes; stop beats threshold, threshold beats tick.
    always_comb begin
        state_next  = state_reg;
        capture     = 1'b0;
        sweep_inc   = 1'b0;
        step_en     = 1'b0;
        step_dec    = 1'b0;
        load_strobe = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    capture    = 1'b1;
                    state_next = (bus.lo > bus.hi) ? S_ERR : S_LOAD;
                end
            end
            S_LOAD: begin
                load_strobe = 1'b1;
                if (bus.stop)
                    state_next = S_IDLE;
                else if ((lo_reg == hi_reg) || (sw_reg == '0))
                    state_next = S_DONE;
                else
                    state_next = S_UP;
            end
            S_UP: begin
                if (bus.stop) begin
                    state_next = S_IDLE;
                end else if (bus.cnt_threshold) begin
                    state_next = S_ERR;
                end else if (tick) begin
                    if (bus.cnt_value < hi_reg)
                        step_en = 1'b1;
                    else
                        state_next = S_DOWN;
                end
            end
            S_DOWN: begin
                if (bus.stop) begin
                    state_next = S_IDLE;
                end else if (bus.cnt_threshold) begin
                    state_next = S_ERR;
                end else if (tick) begin
                    if (bus.cnt_value > lo_reg) begin
                        step_en  = 1'b1;
                        step_dec = 1'b1;
                    end else begin
                        sweep_inc  = 1'b1;
                        state_next = (sweep_cnt_plus == sw_reg) ? S_DONE : S_UP;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Prescaler restarts whenever a ramp state is entered and wraps after each tick.
    always_comb begin
        presc_next = '0;
        if ((state_next == state_reg) && ((state_reg == S_UP) || (state_reg == S_DOWN)) && !tick)
            presc_next = presc_reg + 1'b1;
    end

    // State, prescaler and captured sequence parameters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_IDLE;
            presc_reg <= '0;
            lo_reg    <= '0;
            hi_reg    <= '0;
            sw_reg    <= '0;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            if (capture) begin
                lo_reg <= bus.lo;
                hi_reg <= bus.hi;
                sw_reg <= bus.sweeps;
            end
        end
    end

    // Completed-sweep count survives DONE so the host can read it afterwards.
    always_ff @(posedge clock) begin
        if (reset)
            sweep_cnt_reg <= '0;
        else if (capture)
            sweep_cnt_reg <= '0;
        else if (sweep_inc)
            sweep_cnt_reg <= sweep_cnt_plus;
    end

    // Sticky fault flag; entering ERR wins over the clear of an accepted start.
    always_ff @(posedge clock) begin
        if (reset)
            error_reg <= 1'b0;
        else if (state_next == S_ERR)
            error_reg <= 1'b1;
        else if (capture)
            error_reg <= 1'b0;
    end

    assign bus.cnt_enable = step_en;
    assign bus.cnt_dec    = step_dec;
    assign bus.cnt_load   = load_strobe;
    assign bus.cnt_ref    = (state_reg == S_LOAD) ? lo_reg : hi_reg;
    assign bus.busy       = (state_reg == S_LOAD) || (state_reg == S_UP) || (state_reg == S_DOWN);
    assign bus.done       = (state_reg == S_DONE);
    assign bus.error      = error_reg;
    assign bus.sweep_cnt  = sweep_cnt_reg;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: two instances (TICK_DIV=1 and 4), each with a
// behavioural counter beside it. Every scenario is expanded into a per-cycle
// vector list (inputs plus expected outputs) derived from the ramp rules.
module tb_counter_sweep_ctrl;

    localparam int N  = 4;
    localparam int SW = 4;
    localparam int NI = 2;

    typedef struct {
        bit            rst, start, stop, thr;
        logic [N-1:0]  lo, hi;
        logic [SW-1:0] sw;
        byte           ph;
        bit            en, dec, load, busy, done, err;
        logic [N-1:0]  ref_v, val;
        logic [SW-1:0] sc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    vec_t q [NI][$];
    vec_t tr [$];

    int total = 0;
    int bad   = 0;

    logic [N-1:0]  m_val [NI];
    logic [N-1:0]  m_hi  [NI];
    bit            m_err [NI];
    logic [SW-1:0] m_sc  [NI];
    int            done_cnt [NI];
    int            en_cnt   [NI];
    logic          err_now  [NI];
    logic [SW-1:0] sc_now   [NI];

    logic [N-1:0]  cur_lo, cur_hi;
    logic [SW-1:0] cur_sw;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_inst
            counter_sweep_ctrl_if #(.N(N), .SW(SW)) bus ();
            logic         rst_i;
            logic [N-1:0] cval = '0;
            bit           thr_f;

            counter_sweep_ctrl #(.N(N), .TICK_DIV((gi == 0) ? 1 : 4), .SW(SW)) dut (
                .clock (clk),
                .reset (rst_i),
                .bus   (bus)
            );

            assign bus.cnt_value     = cval;
            assign bus.cnt_threshold = (cval > bus.cnt_ref) || thr_f;

            // companion counter: load has priority, one step per enable
            always @(posedge clk) begin
                if (bus.cnt_load)
                    cval <= bus.cnt_ref;
                else if (bus.cnt_enable)
                    cval <= bus.cnt_dec ? cval - 1'b1 : cval + 1'b1;
            end

            // apply one vector per cycle, compare on the falling edge
            initial begin
                vec_t v;
                bit   have;
                rst_i = 1'b1; thr_f = 1'b0;
                bus.start = 1'b0; bus.stop = 1'b0;
                bus.lo = '0; bus.hi = '0; bus.sweeps = '0;
                forever begin
                    @(posedge clk);
                    #1;
                    have = (q[gi].size() > 0);
                    if (have) begin
                        v = q[gi].pop_front();
                        rst_i = v.rst; bus.start = v.start; bus.stop = v.stop; thr_f = v.thr;
                        bus.lo = v.lo; bus.hi = v.hi; bus.sweeps = v.sw;
                    end else begin
                        rst_i = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; thr_f = 1'b0;
                    end
                    @(negedge clk);
                    if (have) begin
                        total++;
                        if (bus.cnt_enable !== v.en || bus.cnt_dec !== v.dec || bus.cnt_load !== v.load ||
                            bus.busy !== v.busy || bus.done !== v.done || bus.error !== v.err ||
                            bus.cnt_ref !== v.ref_v || bus.sweep_cnt !== v.sc || bus.cnt_value !== v.val) begin
                            bad++;
                            $display("FAIL cycle i%0d ph=%s got en=%b dec=%b ld=%b busy=%b done=%b err=%b ref=%0d sc=%0d val=%0d required en=%b dec=%b ld=%b busy=%b done=%b err=%b ref=%0d sc=%0d val=%0d",
                                     gi, v.ph, bus.cnt_enable, bus.cnt_dec, bus.cnt_load, bus.busy, bus.done,
                                     bus.error, bus.cnt_ref, bus.sweep_cnt, bus.cnt_value,
                                     v.en, v.dec, v.load, v.busy, v.done, v.err, v.ref_v, v.sc, v.val);
                        end
                    end
                    if (bus.done === 1'b1) done_cnt[gi]++;
                    if (bus.cnt_enable === 1'b1) en_cnt[gi]++;
                    err_now[gi] = bus.error;
                    sc_now[gi]  = bus.sweep_cnt;
                end
            end
        end
    endgenerate

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic put(input byte ph, input bit en, input bit dec, input bit load, input bit busy,
                       input bit done, input bit err, input int rf, input int val, input int sc);
        vec_t e;
        e.rst = 0; e.start = 0; e.stop = 0; e.thr = 0;
        e.lo = cur_lo; e.hi = cur_hi; e.sw = cur_sw;
        e.ph = ph; e.en = en; e.dec = dec; e.load = load; e.busy = busy; e.done = done; e.err = err;
        e.ref_v = N'(rf); e.val = N'(val); e.sc = SW'(sc);
        tr.push_back(e);
    endtask

    task automatic commit(input int i);
        vec_t last;
        foreach (tr[j]) q[i].push_back(tr[j]);
        last = tr[tr.size() - 1];
        m_val[i] = last.val; m_hi[i] = last.ref_v; m_err[i] = last.err; m_sc[i] = last.sc;
    endtask

    task automatic idle_n(input int i, input int n);
        tr.delete();
        for (int c = 0; c < n; c++) put("I", 0, 0, 0, 0, 0, m_err[i], m_hi[i], m_val[i], m_sc[i]);
        commit(i);
    endtask

    // mode: 0 plain, 1 stop at first UP cycle with value arg, 2 threshold at
    // DOWN cycle number arg, 3 reset at DOWN cycle number arg, 4 start at cycle arg
    task automatic run_seq(input int i, input int lo, input int hi, input int sw,
                           input int mode, input int arg);
        int td, v, sc, k, nd, nv;
        bit fin;
        td = (i == 0) ? 1 : 4;
        cur_lo = N'(lo); cur_hi = N'(hi); cur_sw = SW'(sw);
        tr.delete();
        put("I", 0, 0, 0, 0, 0, m_err[i], m_hi[i], m_val[i], m_sc[i]);
        tr[0].start = 1;
        v = m_val[i];
        if (lo > hi) begin
            put("E", 0, 0, 0, 0, 0, 1, hi, v, 0);
            put("I", 0, 0, 0, 0, 0, 1, hi, v, 0);
        end else begin
            put("L", 0, 0, 1, 1, 0, 0, lo, v, 0);
            v = lo; sc = 0;
            if (lo == hi || sw == 0) begin
                put("F", 0, 0, 0, 0, 1, 0, hi, v, 0);
            end else begin
                for (int s = 0; s < sw; s++) begin
                    fin = 0;
                    while (!fin) begin
                        for (int p = 0; p < td - 1; p++) put("U", 0, 0, 0, 1, 0, 0, hi, v, sc);
                        if (v < hi) begin put("U", 1, 0, 0, 1, 0, 0, hi, v, sc); v++; end
                        else begin put("U", 0, 0, 0, 1, 0, 0, hi, v, sc); fin = 1; end
                    end
                    fin = 0;
                    while (!fin) begin
                        for (int p = 0; p < td - 1; p++) put("D", 0, 0, 0, 1, 0, 0, hi, v, sc);
                        if (v > lo) begin put("D", 1, 1, 0, 1, 0, 0, hi, v, sc); v--; end
                        else begin put("D", 0, 0, 0, 1, 0, 0, hi, v, sc); sc++; fin = 1; end
                    end
                end
                put("F", 0, 0, 0, 0, 1, 0, hi, v, sc);
            end
            put("I", 0, 0, 0, 0, 0, 0, hi, v, sc);
        end

        k = -1; nd = 0;
        foreach (tr[j]) begin
            if (k < 0) begin
                if (mode == 1 && tr[j].ph == "U" && int'(tr[j].val) == arg) k = j;
                if ((mode == 2 || mode == 3) && tr[j].ph == "D") begin
                    if (nd == arg) k = j;
                    nd++;
                end
            end
        end
        if (mode == 4) k = arg;

        if (k >= 0 && mode != 4) begin
            v  = int'(tr[k].val);
            sc = int'(tr[k].sc);
            nv = v + (tr[k].en ? (tr[k].dec ? -1 : 1) : 0);
            if (mode == 1) begin tr[k].stop = 1; tr[k].en = 0; tr[k].dec = 0; end
            if (mode == 2) begin tr[k].thr = 1; tr[k].en = 0; tr[k].dec = 0; end
            if (mode == 3) tr[k].rst = 1;
            while (tr.size() > k + 1) void'(tr.pop_back());
            if (mode == 1) put("I", 0, 0, 0, 0, 0, 0, hi, v, sc);
            if (mode == 2) begin
                put("E", 0, 0, 0, 0, 0, 1, hi, v, sc);
                put("I", 0, 0, 0, 0, 0, 1, hi, v, sc);
            end
            if (mode == 3) put("I", 0, 0, 0, 0, 0, 0, 0, nv, 0);
        end
        if (k >= 0 && mode == 4) begin
            tr[k].start = 1; tr[k].lo = 4'd0; tr[k].hi = 4'd7; tr[k].sw = 4'd9;
        end
        commit(i);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((q[0].size() > 0 || q[1].size() > 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) begin
            total++; bad++;
            $display("FAIL %s: drain timeout after %0d cycles", name, n);
            q[0].delete(); q[1].delete();
        end
        $display("scenario %s complete", name);
    endtask

    task automatic clr_counts();
        for (int i = 0; i < NI; i++) begin done_cnt[i] = 0; en_cnt[i] = 0; end
    endtask

    initial begin
        int s1v [8] = '{2, 3, 4, 5, 5, 4, 3, 2};
        int nen;
        cur_lo = '0; cur_hi = '0; cur_sw = '0;
        for (int i = 0; i < NI; i++) begin
            m_val[i] = '0; m_hi[i] = '0; m_err[i] = 0; m_sc[i] = '0;
            tr.delete();
            put("I", 0, 0, 0, 0, 0, 0, 0, 0, 0);
            tr[0].rst = 1;
            put("I", 0, 0, 0, 0, 0, 0, 0, 0, 0);
            commit(i);
        end
        clr_counts();

        // single sweep 2..5..2
        for (int i = 0; i < NI; i++) begin
            run_seq(i, 2, 5, 1, 0, 0);
            if (i == 0) begin
                chk("s1_model_len", tr.size(), 12);
                chk("s1_model_done_at_10", int'(tr[10].done), 1);
                for (int c = 2; c <= 9; c++) chk("s1_model_value", int'(tr[c].val), s1v[c - 2]);
            end
        end
        wait_drain("single_sweep");
        for (int i = 0; i < NI; i++) begin
            chk("s1_done_pulses", done_cnt[i], 1);
            chk("s1_sweep_cnt", int'(sc_now[i]), 1);
        end

        // two sweeps 0..2..0
        clr_counts();
        for (int i = 0; i < NI; i++) begin
            run_seq(i, 0, 2, 2, 0, 0);
            nen = 0;
            foreach (tr[j]) nen += int'(tr[j].en);
            chk("s2_model_steps", nen, 8);
            chk("s2_model_len", tr.size(), (i == 0) ? 16 : 52);
        end
        wait_drain("two_sweeps");
        for (int i = 0; i < NI; i++) begin
            chk("s2_enable_pulses", en_cnt[i], 8);
            chk("s2_done_pulses", done_cnt[i], 1);
            chk("s2_sweep_cnt", int'(sc_now[i]), 2);
        end

        // inverted bounds, error held, then cleared by a good start
        clr_counts();
        for (int i = 0; i < NI; i++) begin run_seq(i, 6, 3, 1, 0, 0); idle_n(i, 3); end
        wait_drain("bad_bounds");
        for (int i = 0; i < NI; i++) chk("s3_error_held", int'(err_now[i]), 1);
        for (int i = 0; i < NI; i++) run_seq(i, 1, 2, 1, 0, 0);
        wait_drain("error_clear");
        for (int i = 0; i < NI; i++) chk("s3_error_cleared", int'(err_now[i]), 0);

        // degenerate sequences finish right after LOAD
        clr_counts();
        for (int i = 0; i < NI; i++) begin run_seq(i, 4, 4, 3, 0, 0); run_seq(i, 1, 3, 0, 0, 0); end
        wait_drain("early_done");
        for (int i = 0; i < NI; i++) begin
            chk("s4_no_steps", en_cnt[i], 0);
            chk("s4_done_pulses", done_cnt[i], 2);
        end

        // stop mid-UP at value 3, then reset mid-DOWN
        clr_counts();
        for (int i = 0; i < NI; i++) run_seq(i, 0, 5, 1, 1, 3);
        wait_drain("stop_mid_up");
        for (int i = 0; i < NI; i++) chk("s5_stop_no_done", done_cnt[i], 0);
        for (int i = 0; i < NI; i++) run_seq(i, 1, 4, 1, 3, 1);
        wait_drain("reset_mid_down");

        // forced threshold during DOWN, then start while busy
        for (int i = 0; i < NI; i++) run_seq(i, 1, 4, 2, 2, 2);
        wait_drain("threshold_in_down");
        for (int i = 0; i < NI; i++) chk("s6_error_set", int'(err_now[i]), 1);
        clr_counts();
        for (int i = 0; i < NI; i++) run_seq(i, 2, 6, 1, 4, 3);
        wait_drain("start_while_busy");
        for (int i = 0; i < NI; i++) chk("s6_busy_start_steps", en_cnt[i], 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
Sequencer for the N-bit up/down counter with load and threshold used in the lab designs. On a start command it captures lower and upper bounds (lo, hi). It loads the counter with lo, then ramps it up to hi and back down to lo a programmed number of times (one sweep = up ramp + down ramp). Steps are paced by an internal prescaler. The block only drives the counter's control inputs; the counter instance sits beside it and feeds its value and threshold back.

Parameters:
N, 4, counter width in bits
TICK_DIV, 4, clock cycles per counter step (>=1)
SW, 4, width of sweep-count field

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  begin sequence; sampled only in IDLE
stop  input  1  abort current sequence
lo  input  N  lower bound, captured on accepted start
hi  input  N  upper bound, captured on accepted start
sweeps  input  SW  number of sweeps, captured on accepted start
cnt_value  input  N  current counter value
cnt_threshold  input  1  counter threshold flag (1 when cnt_value > cnt_ref)
cnt_enable  output  1  counter step enable
cnt_dec  output  1  step direction, 1=decrement, 0=increment
cnt_load  output  1  counter load strobe
cnt_ref  output  N  counter load/reference value
busy  output  1  high in LOAD, UP, DOWN
done  output  1  one-cycle pulse on normal completion
error  output  1  sticky fault flag
sweep_cnt  output  SW  completed sweeps in current sequence

Behaviour:
- One clock, reset synchronous active-high. Everything updates on posedge clock.
- Reset has priority over all inputs. It forces state IDLE, prescaler=0 and sweep_cnt=0, and sets outputs to cnt_enable=0, cnt_dec=0, cnt_load=0, busy=0, done=0, error=0.
- cnt_ref resets to 0. It is lo_q in LOAD and hi_q in all other states.
- States: IDLE, LOAD, UP, DOWN, DONE, ERR.
- IDLE:
  - start=1 captures lo/hi/sweeps into lo_q/hi_q/sw_q, clears sweep_cnt and error.
  - If lo>hi (unsigned), go to ERR. Otherwise go to LOAD.
- LOAD (exactly 1 cycle):
  - Outputs: cnt_load=1, cnt_enable=0, cnt_ref=lo_q.
  - If lo_q==hi_q or sw_q==0, go to DONE. Otherwise go to UP.
- Prescaler:
  - Cleared on entry to UP or DOWN, then counts 0..TICK_DIV-1.
  - tick=1 when prescaler==TICK_DIV-1. With TICK_DIV=1, tick is 1 every cycle.
- UP, on tick:
  - If cnt_value<hi_q: cnt_enable=1, cnt_dec=0.
  - If cnt_value==hi_q: no step, go to DOWN.
- DOWN, on tick:
  - If cnt_value>lo_q: cnt_enable=1, cnt_dec=1.
  - If cnt_value==lo_q: no step, sweep_cnt+1. Then go to DONE if the new count equals sw_q, else go to UP.
- cnt_enable, cnt_dec and cnt_load are combinational from state and tick. cnt_enable and cnt_load are never both 1.
- The counter updates one cycle after a step is issued, so a comparison on the next tick always sees the updated value.
- DONE (1 cycle): done=1, then go to IDLE. sweep_cnt holds its value until the next accepted start.
- stop=1 in LOAD, UP or DOWN: next state is IDLE, no step issued that cycle, done stays 0. stop in IDLE or DONE is ignored.
- stop has priority over tick. reset has priority over stop.
- cnt_threshold=1 in UP or DOWN (counter above hi_q): go to ERR, no step issued.
- ERR (1 cycle): error=1, then go to IDLE.
  - error stays high until the next accepted start or reset.
- start while busy is ignored; no re-capture of lo/hi/sweeps.
- busy=1 exactly in LOAD, UP and DOWN.
- All comparisons are unsigned, N bits. The counter never wraps, because steps are gated by the bounds.

Test Plan:
- TICK_DIV=1, lo=2, hi=5, sweeps=1, start pulse at cycle 0 -> LOAD at cycle 1; cnt_value 2,3,4,5,4,3,2 across cycles 2..9; done pulse at cycle 10; sweep_cnt=1; busy low from cycle 10.
- TICK_DIV=4, lo=0, hi=2, sweeps=2 -> cnt_enable pulses exactly every 4th cycle; sequence 0,1,2,1,0,1,2,1,0; one done pulse; sweep_cnt=2.
- lo=6, hi=3, start -> no cnt_load; ERR then IDLE; error=1 held until the next start with lo=1, hi=2, which clears it.
- lo=hi=4, sweeps=3 -> one cnt_load with cnt_ref=4, no cnt_enable, done one cycle after LOAD. Separately, sweeps=0 with lo=1, hi=3 -> same early done.
- Mid-UP at cnt_value=3, assert stop, also reset mid-DOWN -> stop: IDLE next cycle, counter held at 3, no done; reset: all outputs at reset values, state IDLE.
- Force cnt_threshold=1 during DOWN; also pulse start while busy -> threshold: ERR, error=1, no step that cycle; start while busy: no effect on captured bounds or sequence.
